sr_latch: RTL and testbench

// - Clocked, synchronous model of a NAND-style SR latch with active-low Set/Reset inputs.
// - Inputs S and R are synchronised, then decoded into set/reset/hold/forbidden.
//   A stored state bit drives the registered outputs Q/Qbar.
// - Flags the forbidden input condition (S=0,R=0).
// - Used as a glitch-safe storage bit for asynchronous control strobes feeding clocked logic.

---
 rtl/sr_latch_if.sv | 36 +++
 rtl/sr_latch.sv | 129 ++++++++++++
 tb/tb_sr_latch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_if.sv
// sr_latch_if: active-low S/R strobes in, registered Q/Qbar/illegal out.
// illegal_cnt exists only with SR_LATCH_ILLEGAL_CNT_EN defined.
interface sr_latch_if #(
   parameter int CNT_W = 8
);
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic S;
   logic R;
   logic Q;
   logic Qbar;
   logic illegal;
`ifdef SR_LATCH_ILLEGAL_CNT_EN
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output S, R,
      input  Q, Qbar, illegal, illegal_cnt
   );
   modport slave (
      input  S, R,
      output Q, Qbar, illegal, illegal_cnt
   );
`else
   modport master (
      output S, R,
      input  Q, Qbar, illegal
   );
   modport slave (
      input  S, R,
      output Q, Qbar, illegal
   );
`endif
endinterface

// File: rtl/sr_latch.sv
// sr_latch: clocked NAND-style SR latch with synchronised active-low S/R.
// Define SR_LATCH_ILLEGAL_CNT_EN to add the saturating illegal_cnt counter.
module sr_latch #(
   parameter int SYNC_STAGES   = 2,
   parameter int FORBID_POLICY = 0,
   parameter int CNT_W         = 8
) (
   input logic       clk,
   input logic       rst_n,
   sr_latch_if.slave bus
);
   if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("SYNC_STAGES must be 0..3");
   end
   if (FORBID_POLICY < 0 || FORBID_POLICY > 3) begin : g_bad_pol
      $error("FORBID_POLICY must be 0..3");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic s_q;
   logic r_q;

   if (SYNC_STAGES == 0) begin : g_direct
      assign s_q = bus.S;
      assign r_q = bus.R;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] s_ff;
      logic [SYNC_STAGES-1:0] r_ff;

      // Reset to 1 so the chain reads as "hold" after release
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_ff <= '1;
            r_ff <= '1;
         end else begin
            s_ff[0] <= bus.S;
            r_ff[0] <= bus.R;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               s_ff[i] <= s_ff[i-1];
               r_ff[i] <= r_ff[i-1];
            end
         end
      end

      assign s_q = s_ff[SYNC_STAGES-1];
      assign r_q = r_ff[SYNC_STAGES-1];
   end

   logic do_hold;
   logic do_set;
   logic do_clr;
   logic do_forbid;

   assign do_hold   =  s_q &  r_q;
   assign do_set    = ~s_q &  r_q;
   assign do_clr    =  s_q & ~r_q;
   assign do_forbid = ~s_q & ~r_q;

   logic state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= 1'b0;
         bus.Q       <= 1'b0;
         bus.Qbar    <= 1'b1;
         bus.illegal <= 1'b0;
      end else begin
         bus.illegal <= do_forbid;
         unique case (1'b1)
            do_hold: begin
               bus.Q    <= state;
               bus.Qbar <= ~state;
            end
            do_set: begin
               state    <= 1'b1;
               bus.Q    <= 1'b1;
               bus.Qbar <= 1'b0;
            end
            do_clr: begin
               state    <= 1'b0;
               bus.Q    <= 1'b0;
               bus.Qbar <= 1'b1;
            end
            do_forbid: begin
               // Policy 0 mirrors the gates: both NAND outputs high
               case (FORBID_POLICY)
                  0: begin
                     bus.Q    <= 1'b1;
                     bus.Qbar <= 1'b1;
                  end
                  1: begin
                     bus.Q    <= state;
                     bus.Qbar <= ~state;
                  end
                  2: begin
                     state    <= 1'b0;
                     bus.Q    <= 1'b0;
                     bus.Qbar <= 1'b1;
                  end
                  default: begin
                     state    <= 1'b1;
                     bus.Q    <= 1'b1;
                     bus.Qbar <= 1'b0;
                  end
               endcase
            end
            default: begin
               bus.Q    <= state;
               bus.Qbar <= ~state;
            end
         endcase
      end
   end

`ifdef SR_LATCH_ILLEGAL_CNT_EN
   // Counts entries only: the cycle illegal is about to rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.illegal_cnt <= '0;
      end else if (do_forbid && !bus.illegal
                   && bus.illegal_cnt != '1) begin
         bus.illegal_cnt <= bus.illegal_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: four latches (policies 0..3) on shared stimulus,
// scoreboard of expected outputs due three clocks after each drive.
module tb_sr_latch;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sr_latch_if #(.CNT_W(CW)) b0 ();
   sr_latch_if #(.CNT_W(CW)) b1 ();
   sr_latch_if #(.CNT_W(CW)) b2 ();
   sr_latch_if #(.CNT_W(CW)) b3 ();

   sr_latch #(.SYNC_STAGES(2), .FORBID_POLICY(0), .CNT_W(CW))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   sr_latch #(.SYNC_STAGES(2), .FORBID_POLICY(1), .CNT_W(CW))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   sr_latch #(.SYNC_STAGES(2), .FORBID_POLICY(2), .CNT_W(CW))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   sr_latch #(.SYNC_STAGES(2), .FORBID_POLICY(3), .CNT_W(CW))
      u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   logic [2:0] obs [4];
   assign obs[0] = {b0.Q, b0.Qbar, b0.illegal};
   assign obs[1] = {b1.Q, b1.Qbar, b1.illegal};
   assign obs[2] = {b2.Q, b2.Qbar, b2.illegal};
   assign obs[3] = {b3.Q, b3.Qbar, b3.illegal};

   typedef struct {
      int              due;
      logic [3:0][2:0] o;
      logic [CW-1:0]   cnt;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic          m_st [4];
   logic          m_il;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e0,
                          input logic [2:0] e1, input logic [2:0] e2,
                          input logic [2:0] e3);
      chk({tag, "_p0"}, {5'd0, obs[0]}, {5'd0, e0});
      chk({tag, "_p1"}, {5'd0, obs[1]}, {5'd0, e1});
      chk({tag, "_p2"}, {5'd0, obs[2]}, {5'd0, e2});
      chk({tag, "_p3"}, {5'd0, obs[3]}, {5'd0, e3});
   endtask

   task automatic model_rst();
      for (int k = 0; k < 4; k++) m_st[k] = 1'b0;
      m_il = 1'b0;
      m_cnt = '0;
   endtask

   // Expected {Q,Qbar,illegal} for policy p after decoding (s,r)
   task automatic model(input int p, input logic s, input logic r,
                        output logic [2:0] o);
      if (s && r) begin
         o = {m_st[p], ~m_st[p], 1'b0};
      end else if (!s && r) begin
         m_st[p] = 1'b1;
         o = 3'b100;
      end else if (s && !r) begin
         m_st[p] = 1'b0;
         o = 3'b010;
      end else begin
         case (p)
            0: o = 3'b111;
            1: o = {m_st[p], ~m_st[p], 1'b1};
            2: begin m_st[p] = 1'b0; o = 3'b011; end
            default: begin m_st[p] = 1'b1; o = 3'b101; end
         endcase
      end
   endtask

   task automatic drive(input logic s, input logic r);
      b0.S = s; b0.R = r;
      b1.S = s; b1.R = r;
      b2.S = s; b2.R = r;
      b3.S = s; b3.R = r;
   endtask

   task automatic push(input logic s, input logic r);
      exp_t e;
      logic [2:0] o;
      logic il;
      for (int k = 0; k < 4; k++) begin
         model(k, s, r, o);
         e.o[k] = o;
      end
      il = !s && !r;
      if (il && !m_il && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      m_il = il;
      e.cnt = m_cnt;
      e.due = cyc + 3;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         for (int k = 0; k < 4; k++)
            chk($sformatf("sb_c%0d_p%0d", e.due, k),
                {5'd0, obs[k]}, {5'd0, e.o[k]});
`ifdef SR_LATCH_ILLEGAL_CNT_EN
         chk($sformatf("sb_cnt_c%0d", e.due),
             {6'd0, b0.illegal_cnt}, {6'd0, e.cnt});
`endif
      end
   endtask

   task automatic step(input logic s, input logic r);
      #4;
      drive(s, r);
      push(s, r);
      tick();
   endtask

   task automatic settle(input logic s, input logic r);
      repeat (4) step(s, r);
   endtask

   // Reset pulse inside a cycle, no clock edge while asserted
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(tag, 3'b010, 3'b010, 3'b010, 3'b010);
`ifdef SR_LATCH_ILLEGAL_CNT_EN
      chk({tag, "_cnt"}, {6'd0, b0.illegal_cnt}, 8'd0);
`endif
      sb.delete();
      model_rst();
      drive(1'b1, 1'b1);
      #4;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      model_rst();
      drive(1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 3'b010, 3'b010, 3'b010, 3'b010);
`ifdef SR_LATCH_ILLEGAL_CNT_EN
      chk("reset_cnt", {6'd0, b0.illegal_cnt}, 8'd0);
`endif
      #4;
      rst_n = 1'b1;
      tick();

      settle(1'b1, 1'b1);
      chk_all("hold0", 3'b010, 3'b010, 3'b010, 3'b010);

      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);

      settle(1'b0, 1'b1);
      chk_all("set", 3'b100, 3'b100, 3'b100, 3'b100);
      settle(1'b0, 1'b0);
      chk_all("fb_q1", 3'b111, 3'b101, 3'b011, 3'b101);
      settle(1'b1, 1'b1);
      chk_all("exit_q1", 3'b100, 3'b100, 3'b010, 3'b100);
      settle(1'b1, 1'b0);
      chk_all("clr", 3'b010, 3'b010, 3'b010, 3'b010);
      settle(1'b0, 1'b0);
      chk_all("fb_q0", 3'b111, 3'b011, 3'b011, 3'b101);
      settle(1'b1, 1'b1);
      chk_all("exit_q0", 3'b010, 3'b010, 3'b010, 3'b100);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      settle(1'b1, 1'b1);

      settle(1'b0, 1'b1);
      chk_all("pre_rst", 3'b100, 3'b100, 3'b100, 3'b100);
      mid_reset("mid_rst1");
      settle(1'b1, 1'b1);
      chk_all("post_rst", 3'b010, 3'b010, 3'b010, 3'b010);

      for (int n = 1; n <= 5; n++) begin
         step(1'b0, 1'b0);
         settle(1'b1, 1'b1);
`ifdef SR_LATCH_ILLEGAL_CNT_EN
         chk($sformatf("cnt_entry%0d", n), {6'd0, b0.illegal_cnt},
             (n < 3) ? 8'(n) : 8'd3);
`endif
      end

      mid_reset("mid_rst2");
      repeat (4) step(1'b0, 1'b0);
      settle(1'b1, 1'b1);
`ifdef SR_LATCH_ILLEGAL_CNT_EN
      chk("cnt_long", {6'd0, b0.illegal_cnt}, 8'd1);
`endif
      chk_all("final", 3'b111 & 3'b010, 3'b010, 3'b010, 3'b100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
